hwag_spi_tx_data_frame: RTL and testbench

- Builds the slave-to-master SPI response frame: [STATUS8]:[ADDR8]:[DATA32]:[CRC8], 7 bytes, MSB byte first.
- Mirrors the receive-side frame on the other wire.
- A valid READ command received in frame N triggers a register fetch; the fetched word is transmitted in frame N+1.
- Sits between the rx frame decoder / register file and the spi_slave bus_in port.

---
 rtl/hwag_spi_pkg.sv | 26 ++
 rtl/crc8_byte.sv | 21 ++
 rtl/hwag_spi_tx_data_frame.sv | 169 ++++++++++++++++
 tb/tb_hwag_spi_tx_data_frame.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_spi_pkg.sv
// Shared SPI frame definitions for the rx decoder and the tx frame builder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hwag_spi_pkg;

    localparam logic [7:0] CMD_READ    = 8'h01;
    localparam logic [7:0] CMD_WRITE   = 8'h02;

    // STATUS, ADDR, DATA[31:24..7:0], CRC
    localparam int         FRAME_BYTES = 7;
    localparam logic [7:0] CRC8_POLY   = 8'h07;

    // STATUS byte bit positions; [7:4] carry the frame sequence counter
    localparam int ST_CRC_OK  = 0;
    localparam int ST_VALID   = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_BUSY    = 3;
    localparam int ST_SEQ_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/crc8_byte.sv
// One-byte CRC-8 step (poly from package, MSB first, no reflection, no final XOR).
// Latency: combinational.
// Backpressure: none.
// Ports: crc_in - running CRC, byte_in - byte to absorb, crc_out - updated CRC.
module crc8_byte (
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);
    import hwag_spi_pkg::*;

    always_comb begin
        logic [7:0] c;
        c = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/hwag_spi_tx_data_frame.sv
// Builds the 7-byte slave response frame STATUS:ADDR:DATA32:CRC8 and runs the register fetch behind it.
// Latency: frame snapshot at ss fall; each byte presented combinationally from the byte index; read request 1 clk after the READ frame ends.
// Backpressure: bytes advance only on spi_tx; fetch holds rd_req until rd_ack or RD_TIMEOUT clks.
// Ports: clk/nrst (sync, active low); spi_ss/spi_ss_rise/spi_tx from spi_slave, spi_bus_in to its shifter;
//        rx_cmd/rx_addr/rx_crc_equal from the rx decoder; rd_req/rd_addr/rd_data/rd_ack to the register file;
//        tx_frame_done pulses once the CRC byte has been taken.
module hwag_spi_tx_data_frame #(
    parameter int         RD_TIMEOUT = 16,
    parameter logic [7:0] CMD_READ   = hwag_spi_pkg::CMD_READ
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        spi_ss,
    input  logic        spi_ss_rise,
    input  logic        spi_tx,
    output logic [7:0]  spi_bus_in,
    input  logic [7:0]  rx_cmd,
    input  logic [7:0]  rx_addr,
    input  logic        rx_crc_equal,
    output logic        rd_req,
    output logic [7:0]  rd_addr,
    input  logic [31:0] rd_data,
    input  logic        rd_ack,
    output logic        tx_frame_done
);
    import hwag_spi_pkg::*;

    localparam int         TW      = $clog2(RD_TIMEOUT + 1);
    localparam logic [2:0] IDX_CRC = 3'(FRAME_BYTES - 1);
    localparam logic [2:0] IDX_END = 3'(FRAME_BYTES);

    fetch_state_t state_q, state_d;

    logic          ss_q;
    logic [31:0]   data_buf_q;
    logic          valid_q, timeout_q, crc_ok_q;
    logic [3:0]    seq_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [47:0]   frame_q;
    logic          consumed_q;
    logic [2:0]    byte_idx_q;
    logic [7:0]    crc_q, crc_next;
    logic [7:0]    status;

    logic ss_fall, tx_take, rd_go, frame_full, consume, tmo_hit;

    assign ss_fall    = ss_q & ~spi_ss;
    assign tx_take    = spi_tx & ~spi_ss & ~ss_fall;
    assign rd_go      = spi_ss_rise & rx_crc_equal & (rx_cmd == CMD_READ);
    assign frame_full = (byte_idx_q == IDX_END);
    // consumed_q is only ever set from a snapshot taken in READY, so this
    // retires exactly the buffer that went out on the wire
    assign consume    = spi_ss_rise & frame_full & consumed_q;
    assign tmo_hit    = (state_q == FETCH) & ~rd_ack & (tmo_cnt_q == TW'(RD_TIMEOUT - 1));

    always_comb begin
        status                  = '0;
        status[ST_CRC_OK]       = crc_ok_q;
        status[ST_VALID]        = valid_q;
        status[ST_TIMEOUT]      = timeout_q;
        status[ST_BUSY]         = (state_q == FETCH);
        status[ST_SEQ_LSB +: 4] = seq_q;
    end

    always_comb begin
        case (byte_idx_q)
            3'd0:    spi_bus_in = frame_q[47:40];
            3'd1:    spi_bus_in = frame_q[39:32];
            3'd2:    spi_bus_in = frame_q[31:24];
            3'd3:    spi_bus_in = frame_q[23:16];
            3'd4:    spi_bus_in = frame_q[15:8];
            3'd5:    spi_bus_in = frame_q[7:0];
            3'd6:    spi_bus_in = crc_q;
            default: spi_bus_in = 8'hFF;
        endcase
    end

    crc8_byte u_crc8 (
        .crc_in  (crc_q),
        .byte_in (spi_bus_in),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_go) state_d = FETCH;
            FETCH:   if (rd_go) state_d = FETCH;
                     else if (rd_ack || tmo_hit) state_d = READY;
            READY:   if (rd_go) state_d = FETCH;
                     else if (consume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ss_q          <= 1'b1;  // idle level, so a held-low ss after reset snapshots the cleared state
            rd_req        <= 1'b0;
            rd_addr       <= '0;
            data_buf_q    <= '0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
            crc_ok_q      <= 1'b0;
            seq_q         <= '0;
            tmo_cnt_q     <= '0;
            frame_q       <= '0;
            consumed_q    <= 1'b0;
            byte_idx_q    <= '0;
            crc_q         <= '0;
            tx_frame_done <= 1'b0;
        end else begin
            ss_q          <= spi_ss;
            tx_frame_done <= 1'b0;

            if (spi_ss_rise) begin
                crc_ok_q <= rx_crc_equal;
                if (frame_full) seq_q <= seq_q + 4'd1;
            end

            // a new READ always wins: old buffer is dropped and the fetch (re)starts
            if (rd_go) begin
                rd_addr    <= rx_addr;
                rd_req     <= 1'b1;
                data_buf_q <= '0;
                valid_q    <= 1'b0;
                timeout_q  <= 1'b0;
                tmo_cnt_q  <= '0;
            end else if (state_q == FETCH) begin
                if (rd_ack) begin
                    data_buf_q <= rd_data;
                    valid_q    <= 1'b1;
                    rd_req     <= 1'b0;
                end else if (tmo_hit) begin
                    data_buf_q <= '0;
                    timeout_q  <= 1'b1;
                    valid_q    <= 1'b1;
                    rd_req     <= 1'b0;
                end else begin
                    tmo_cnt_q  <= tmo_cnt_q + TW'(1);
                end
            end else if (consume) begin
                valid_q   <= 1'b0;
                timeout_q <= 1'b0;
            end

            // frame is frozen at ss fall; later fetch results wait for the next frame
            if (ss_fall) begin
                frame_q    <= {status, rd_addr, data_buf_q};
                consumed_q <= valid_q;
                byte_idx_q <= '0;
                crc_q      <= '0;
            end else begin
                if (consume) consumed_q <= 1'b0;
                if (tx_take) begin
                    if (byte_idx_q < IDX_CRC)   crc_q         <= crc_next;
                    if (byte_idx_q == IDX_CRC)  tx_frame_done <= 1'b1;
                    if (byte_idx_q != IDX_END)  byte_idx_q    <= byte_idx_q + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hwag_spi_tx_data_frame.sv
module tb_hwag_spi_tx_data_frame;

    localparam int RD_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        nrst, spi_ss, spi_ss_rise, spi_tx;
    logic [7:0]  spi_bus_in, rx_cmd, rx_addr, rd_addr;
    logic        rx_crc_equal, rd_req, rd_ack, tx_frame_done;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    hwag_spi_tx_data_frame #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .spi_ss        (spi_ss),
        .spi_ss_rise   (spi_ss_rise),
        .spi_tx        (spi_tx),
        .spi_bus_in    (spi_bus_in),
        .rx_cmd        (rx_cmd),
        .rx_addr       (rx_addr),
        .rx_crc_equal  (rx_crc_equal),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_ack        (rd_ack),
        .tx_frame_done (tx_frame_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of what the slave reports ----------------
    logic [3:0]  m_seq;
    logic        m_crc_ok, m_pending, m_have, m_to;
    logic [7:0]  m_addr;
    logic [31:0] m_data;

    task automatic model_reset();
        m_seq = '0; m_crc_ok = 0; m_pending = 0; m_have = 0; m_to = 0;
        m_addr = '0; m_data = '0;
    endtask

    // bit-serial CRC-8, poly x^8+x^2+x+1, over the 6 payload bytes, MSB first
    function automatic logic [7:0] crc_of(input logic [47:0] f);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 47; i >= 0; i--) begin
            fb = c[7] ^ f[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    logic [7:0] exp_b [0:7];
    logic [7:0] cap   [0:7];
    logic       snap_valid;

    task automatic build_expect();
        logic [7:0]  st;
        logic [47:0] f;
        st = {m_seq, m_pending, m_to, m_have, m_crc_ok};
        f  = {st, m_addr, m_data};
        for (int i = 0; i < 6; i++) exp_b[i] = f[47-8*i -: 8];
        exp_b[6]   = crc_of(f);
        exp_b[7]   = 8'hFF;
        snap_valid = m_have;
    endtask

    // ---------------- compare process ----------------
    logic chk_en = 1'b0;
    int   b_idx  = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (tx_frame_done) begin
            done_cnt++;
            chk("done_at_byte7", b_idx, 7);
        end
        if (chk_en) begin
            chk($sformatf("byte%0d", b_idx), spi_bus_in, exp_b[b_idx]);
            cap[b_idx] = spi_bus_in;
        end
    end

    // ---------------- register file responder ----------------
    int          cfg_delay = 100;
    logic [31:0] cfg_data  = '0;
    int          req_len   = 0;
    logic        acked     = 0;

    initial begin
        rd_ack  = 0;
        rd_data = '0;
        forever begin
            @(posedge clk); #1;
            rd_ack  = 0;
            rd_data = $urandom;
            if (!nrst) begin
                req_len = 0;
                acked   = 0;
            end else if (rd_req) begin
                req_len++;
                if (req_len == 1) chk("rd_addr", rd_addr, m_addr);
                if (req_len == cfg_delay) begin
                    rd_ack  = 1;
                    rd_data = cfg_data;
                    acked   = 1;
                end
            end else if (req_len > 0) begin
                if (acked) begin
                    chk("rd_req_len_ack", req_len, cfg_delay);
                    m_data = cfg_data;
                    m_to   = 0;
                end else begin
                    chk("rd_req_len_timeout", req_len, RD_TIMEOUT);
                    m_data = '0;
                    m_to   = 1;
                end
                m_have = 1; m_pending = 0;
                req_len = 0; acked = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached after %0d comparisons", total);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int nb, input logic [7:0] cmd, input logic [7:0] addr, input logic crc_eq);
        logic complete;
        spi_ss = 0;
        tick();
        build_expect();
        b_idx = 0; done_cnt = 0; chk_en = 1;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(1, 2)) tick();
            spi_tx = 1;
            tick();
            spi_tx = 0;
            if (b_idx < 7) b_idx++;
        end
        tick(); tick();
        chk_en = 0;
        chk("frame_done_pulses", done_cnt, (nb >= 7) ? 1 : 0);
        // end of frame and what the rx side decoded from it
        complete = (nb >= 7);
        m_crc_ok = crc_eq;
        if (complete) m_seq = m_seq + 4'd1;
        if (crc_eq && cmd == 8'h01) begin
            m_pending = 1; m_have = 0; m_to = 0; m_data = '0; m_addr = addr;
        end else if (complete && snap_valid) begin
            m_have = 0; m_to = 0;
        end
        spi_ss = 1; spi_ss_rise = 1; rx_cmd = cmd; rx_addr = addr; rx_crc_equal = crc_eq;
        tick();
        spi_ss_rise = 0; rx_cmd = '0; rx_addr = '0; rx_crc_equal = 0;
    endtask

    logic [7:0]  cap_d [0:2];
    logic [31:0] dat;

    initial begin
        nrst = 0; spi_ss = 1; spi_ss_rise = 0; spi_tx = 0;
        rx_cmd = '0; rx_addr = '0; rx_crc_equal = 0;
        model_reset();
        repeat (3) tick();
        chk("rst_bus", spi_bus_in, 8'h00);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 8'h00);
        chk("rst_done", tx_frame_done, 0);
        nrst = 1;
        tick();

        // idle frame with filler, READ 0x12 decoded at its end
        cfg_delay = 3; cfg_data = 32'hDEADBEEF;
        run_frame(9, 8'h01, 8'h12, 1);
        chk("idle_status", cap[0], 8'h00);
        chk("idle_crc", cap[6], 8'h00);
        chk("idle_filler", cap[7], 8'hFF);
        repeat (10) tick();

        // fetched word goes out
        run_frame(7, 8'h00, 8'h00, 1);
        chk("rd_status", cap[0], 8'h13);
        chk("rd_addr_byte", cap[1], 8'h12);
        chk("rd_d3", cap[2], 8'hDE);
        chk("rd_d2", cap[3], 8'hAD);
        chk("rd_d1", cap[4], 8'hBE);
        chk("rd_d0", cap[5], 8'hEF);
        repeat (3) tick();

        // READ without ack -> timeout
        cfg_delay = 100;
        run_frame(7, 8'h01, 8'h5A, 1);
        repeat (25) tick();

        // aborted after 3 bytes
        run_frame(3, 8'h00, 8'h00, 1);
        chk("tmo_status_bits", cap[0] & 8'h06, 8'h06);
        chk("tmo_addr", cap[1], 8'h5A);
        chk("tmo_data", cap[2], 8'h00);
        for (int i = 0; i < 3; i++) cap_d[i] = cap[i];
        repeat (3) tick();

        // retransmission, then a READ whose ack lands inside the next frame
        cfg_delay = 12; dat = $urandom; cfg_data = dat;
        run_frame(7, 8'h01, 8'hA7, 1);
        for (int i = 0; i < 3; i++) chk($sformatf("retx_byte%0d", i), cap[i], cap_d[i]);
        repeat (2) tick();
        run_frame(7, 8'h00, 8'h00, 1);
        chk("midframe_busy", cap[0] & 8'h0A, 8'h08);
        chk("midframe_data", cap[2], 8'h00);
        repeat (3) tick();
        run_frame(7, 8'h00, 8'h00, 1);
        chk("next_valid", cap[0] & 8'h0A, 8'h02);
        chk("next_d3", cap[2], dat[31:24]);
        chk("next_d0", cap[5], dat[7:0]);
        repeat (5) tick();

        // randomized traffic
        for (int n = 0; n < 24; n++) begin
            int nb;
            logic [7:0] cmd;
            nb  = ($urandom_range(0, 9) < 7) ? $urandom_range(7, 9) : $urandom_range(0, 6);
            cmd = ($urandom_range(0, 1) == 0) ? 8'h01 : (8'h02 + 8'($urandom_range(0, 200)));
            cfg_delay = $urandom_range(1, 20);
            cfg_data  = $urandom;
            run_frame(nb, cmd, 8'($urandom), ($urandom_range(0, 3) != 0));
            repeat (30) tick();
        end

        // reset while fetching and mid-frame
        cfg_delay = 100;
        run_frame(7, 8'h01, 8'h77, 1);
        repeat (3) tick();
        spi_ss = 0; tick();
        spi_tx = 1; tick(); spi_tx = 0; tick();
        spi_tx = 1; tick(); spi_tx = 0; tick();
        nrst = 0;
        tick();
        chk("midrst_rd_req", rd_req, 0);
        chk("midrst_bus", spi_bus_in, 8'h00);
        chk("midrst_rd_addr", rd_addr, 8'h00);
        model_reset();
        tick();
        nrst = 1;
        spi_ss = 1; spi_ss_rise = 1; rx_crc_equal = 0;
        tick();
        spi_ss_rise = 0;
        repeat (3) tick();
        run_frame(7, 8'h00, 8'h00, 0);
        chk("postrst_status", cap[0], 8'h00);
        chk("postrst_addr", cap[1], 8'h00);
        chk("postrst_d3", cap[2], 8'h00);
        chk("postrst_d0", cap[5], 8'h00);
        chk("postrst_crc", cap[6], 8'h00);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
